// File: rtl/sbox_share_scheduler_if.sv
// Handshake/bus bundle between round-datapath requesters, the PRNG, the shared
// masked S-box core and the result consumer.
interface sbox_share_scheduler_if #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned SHARES  = 4,
  parameter int unsigned FRESH_W = 130
);
  localparam int unsigned VEC_W = 4 * SHARES;
  localparam int unsigned ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ*VEC_W-1:0] req_data;

  logic                   rnd_valid;
  logic                   rnd_ready;
  logic [FRESH_W-1:0]     rnd_data;

  logic [VEC_W-1:0]       sbox_in;
  logic [FRESH_W-1:0]     sbox_fresh;
  logic                   sbox_start;
  logic [VEC_W-1:0]       sbox_out;

  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [VEC_W-1:0]       rsp_data;
  logic [ID_W-1:0]        rsp_id;

  logic                   busy;

  modport slave (
    input  req_valid, req_data, rnd_valid, rnd_data, sbox_out, rsp_ready,
    output req_ready, rnd_ready, sbox_in, sbox_fresh, sbox_start,
           rsp_valid, rsp_data, rsp_id, busy
  );

  modport master (
    output req_valid, req_data, rnd_valid, rnd_data, sbox_out, rsp_ready,
    input  req_ready, rnd_ready, sbox_in, sbox_fresh, sbox_start,
           rsp_valid, rsp_data, rsp_id, busy
  );
endinterface

// File: rtl/sbox_share_scheduler.sv
// Round-robin scheduler time-sharing one masked 4-bit S-box core among N_REQ
// lanes; whole share vectors and one fresh PRNG word per evaluation.
module sbox_share_scheduler #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned SHARES  = 4,
  parameter int unsigned LATENCY = 11,
  parameter int unsigned FRESH_W = 130
) (
  input  logic                 clk,
  input  logic                 rst,
  sbox_share_scheduler_if.slave bus
);

  localparam int unsigned VEC_W = 4 * SHARES;
  localparam int unsigned ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    RAND,
    EVAL,
    DONE
  } state_t;

  state_t             state_q;
  logic [ID_W-1:0]    ptr_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [VEC_W-1:0]   sbox_in_q;
  logic [FRESH_W-1:0] sbox_fresh_q;
  logic               sbox_start_q;
  logic [VEC_W-1:0]   rsp_data_q;
  logic [ID_W-1:0]    rsp_id_q;
  logic               rsp_valid_q;
  logic               rnd_ready_q;
  logic               busy_q;

  logic               gnt_found_d;
  logic [ID_W-1:0]    gnt_idx_d;
  logic [N_REQ-1:0]   gnt_onehot_d;
  logic [ID_W-1:0]    ptr_d;
  logic [VEC_W-1:0]   gnt_vec_d;

  function automatic logic [ID_W-1:0] rr_index(input logic [ID_W-1:0] base,
                                               input int unsigned off);
    int unsigned sum;
    sum = 32'(base) + off;
    return ID_W'(sum % N_REQ);
  endfunction

  // First asserted requester at or after the pointer, wrapping around.
  always_comb begin
    gnt_found_d = 1'b0;
    gnt_idx_d   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!gnt_found_d && bus.req_valid[rr_index(ptr_q, i)]) begin
        gnt_found_d = 1'b1;
        gnt_idx_d   = rr_index(ptr_q, i);
      end
    end
  end

  // Grant is combinational; gating with rst keeps req_ready low while reset is held.
  always_comb begin
    gnt_onehot_d = '0;
    if (rst && (state_q == IDLE) && gnt_found_d) begin
      gnt_onehot_d[gnt_idx_d] = 1'b1;
    end
  end

  assign ptr_d     = (32'(gnt_idx_d) == N_REQ - 1) ? '0 : gnt_idx_d + 1'b1;
  assign gnt_vec_d = bus.req_data[32'(gnt_idx_d)*VEC_W +: VEC_W];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      cnt_q        <= '0;
      sbox_in_q    <= '0;
      sbox_fresh_q <= '0;
      sbox_start_q <= 1'b0;
      rsp_data_q   <= '0;
      rsp_id_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rnd_ready_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      sbox_start_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (gnt_found_d) begin
            sbox_in_q   <= gnt_vec_d;
            rsp_id_q    <= gnt_idx_d;
            ptr_q       <= ptr_d;
            rnd_ready_q <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= RAND;
          end
        end
        RAND: begin
          if (bus.rnd_valid) begin
            sbox_fresh_q <= bus.rnd_data;
            sbox_start_q <= 1'b1;
            cnt_q        <= '0;
            rnd_ready_q  <= 1'b0;
            state_q      <= EVAL;
          end
        end
        EVAL: begin
          if (cnt_q == CNT_LAST) begin
            rsp_data_q  <= bus.sbox_out;
            rsp_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = gnt_onehot_d;
  assign bus.rnd_ready  = rnd_ready_q;
  assign bus.sbox_in    = sbox_in_q;
  assign bus.sbox_fresh = sbox_fresh_q;
  assign bus.sbox_start = sbox_start_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_sbox_share_scheduler.sv
// Bench for sbox_share_scheduler: emulated S-box core, cycle-timeline reference
// model, response scoreboard with a decoupled monitor.
module tb_sbox_share_scheduler;

  localparam int unsigned N_REQ   = 4;
  localparam int unsigned SHARES  = 4;
  localparam int unsigned LATENCY = 11;
  localparam int unsigned FRESH_W = 130;
  localparam int unsigned VEC_W   = 4 * SHARES;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sbox_share_scheduler_if #(.N_REQ(N_REQ), .SHARES(SHARES), .FRESH_W(FRESH_W)) bus ();

  sbox_share_scheduler #(
    .N_REQ(N_REQ), .SHARES(SHARES), .LATENCY(LATENCY), .FRESH_W(FRESH_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned tcyc = 0;
  always @(posedge clk) tcyc <= tcyc + 1;

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, tcyc);
    end
  endtask

  function automatic logic [3:0] present_sbox(input logic [3:0] x);
    logic [63:0] tbl;
    tbl = 64'h21_74_8F_E3_DA_09_B6_5C;
    return tbl[4*x +: 4];
  endfunction

  // Masked core behaviour: unmask, substitute, remask with fresh bits.
  function automatic logic [VEC_W-1:0] sbox_model(input logic [VEC_W-1:0] in_sh,
                                                  input logic [FRESH_W-1:0] fr);
    logic [3:0] x;
    logic [3:0] acc;
    logic [VEC_W-1:0] o;
    x = '0;
    for (int unsigned s = 0; s < SHARES; s++) x ^= in_sh[4*s +: 4];
    acc = present_sbox(x);
    o = '0;
    for (int unsigned s = 0; s + 1 < SHARES; s++) begin
      o[4*s +: 4] = fr[4*s +: 4] ^ fr[4*s+64 +: 4];
      acc ^= o[4*s +: 4];
    end
    o[4*(SHARES-1) +: 4] = acc;
    return o;
  endfunction

  function automatic logic [FRESH_W-1:0] rand_word();
    logic [159:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return t[FRESH_W-1:0];
  endfunction

  // Emulated core: output is only correct exactly LATENCY-1 cycles after start.
  int unsigned core_age;
  always @(posedge clk or negedge rst) begin
    if (!rst) core_age <= 1000;
    else if (bus.sbox_start) core_age <= 1;
    else if (core_age < 1000) core_age <= core_age + 1;
  end
  assign bus.sbox_out = (((bus.sbox_start ? 0 : core_age) == LATENCY - 1))
                        ? sbox_model(bus.sbox_in, bus.sbox_fresh)
                        : ~sbox_model(bus.sbox_in, bus.sbox_fresh);

  typedef struct {
    int unsigned      id;
    logic [VEC_W-1:0] data;
  } exp_t;
  exp_t exp_q[$];

  // Reference model state (transaction timeline)
  bit                 m_busy, m_hs, found, in_done, prev_rsp_valid;
  int unsigned        m_ptr, m_id, m_hs_cyc, m_resp_cyc, g_idx, j, dec;
  logic [VEC_W-1:0]   m_in;
  logic [FRESH_W-1:0] m_fresh;
  logic [N_REQ-1:0]   exp_gnt, gnt_last;
  bit                 hs_event;
  int unsigned        handshakes = 0;
  int unsigned        evals = 0;
  int unsigned        acc_cyc = 0;
  int unsigned        glog_id[$], glog_cyc[$], rise_cyc[$];
  exp_t               e_new, e_pop;

  always @(negedge clk) begin
    gnt_last = '0;
    hs_event = 1'b0;
    if (!rst) begin
      chk("reset_outputs", {bus.req_ready, bus.rnd_ready, bus.sbox_start, bus.rsp_valid,
                            bus.busy, bus.sbox_in, bus.rsp_data, bus.rsp_id}, '0);
      chk("reset_fresh", bus.sbox_fresh, '0);
      m_busy = 1'b0;
      m_hs   = 1'b0;
      m_ptr  = 0;
      exp_q.delete();
    end else begin
      exp_gnt = '0;
      found   = 1'b0;
      g_idx   = 0;
      if (!m_busy) begin
        for (int unsigned k = 0; k < N_REQ; k++) begin
          j = (m_ptr + k) % N_REQ;
          if (!found && bus.req_valid[j]) begin
            found = 1'b1;
            g_idx = j;
          end
        end
      end
      if (found) exp_gnt[g_idx] = 1'b1;
      in_done = m_busy && m_hs && (tcyc >= m_resp_cyc);
      chk("req_ready", bus.req_ready, exp_gnt);
      chk("rnd_ready", bus.rnd_ready, m_busy && !m_hs);
      chk("busy", bus.busy, m_busy);
      chk("sbox_start", bus.sbox_start, m_busy && m_hs && (tcyc == m_hs_cyc + 1));
      chk("rsp_valid", bus.rsp_valid, in_done);
      if (m_busy) chk("sbox_in_stable", bus.sbox_in, m_in);
      if (m_busy && m_hs) chk("sbox_fresh_stable", bus.sbox_fresh, m_fresh);
      if (in_done) begin
        chk("rsp_id_hold", bus.rsp_id, m_id);
        chk("rsp_data_hold", bus.rsp_data, sbox_model(m_in, m_fresh));
      end
      if (bus.req_ready != '0) begin
        dec = 255;
        for (int unsigned k = 0; k < N_REQ; k++) if (bus.req_ready == (N_REQ'(1) << k)) dec = k;
        glog_id.push_back(dec);
        glog_cyc.push_back(tcyc);
      end
      if (bus.rsp_valid && !prev_rsp_valid) rise_cyc.push_back(tcyc);

      if (!m_busy) begin
        if (found) begin
          m_busy   = 1'b1;
          m_hs     = 1'b0;
          m_id     = g_idx;
          m_in     = bus.req_data[g_idx*VEC_W +: VEC_W];
          m_ptr    = (g_idx + 1) % N_REQ;
          gnt_last = exp_gnt;
        end
      end else if (!m_hs) begin
        if (bus.rnd_valid) begin
          m_hs       = 1'b1;
          m_hs_cyc   = tcyc;
          m_resp_cyc = tcyc + LATENCY + 1;
          m_fresh    = bus.rnd_data;
          e_new.id   = m_id;
          e_new.data = sbox_model(m_in, m_fresh);
          exp_q.push_back(e_new);
          handshakes++;
          hs_event = 1'b1;
        end
      end else if (in_done && bus.rsp_ready) begin
        m_busy = 1'b0;
      end
    end
    prev_rsp_valid = bus.rsp_valid;
  end

  // Monitor: pops the scoreboard whenever the DUT hands over a result.
  always @(negedge clk) begin
    if (rst && bus.rsp_valid && bus.rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL scoreboard_underflow: got response id %0d expected none", bus.rsp_id);
      end else begin
        e_pop = exp_q.pop_front();
        chk("rsp_id", bus.rsp_id, e_pop.id);
        chk("rsp_data", bus.rsp_data, e_pop.data);
      end
      evals++;
      acc_cyc = tcyc;
    end
  end

  // Driver
  bit          rand_mode = 1'b0;
  bit          hold_req  = 1'b0;
  int unsigned stall_left = 0;
  int unsigned bp_left    = 0;

  task automatic drive_cycle();
    @(posedge clk);
    #1;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (gnt_last[k]) begin
        if (rand_mode) begin
          bus.req_valid[k] = 1'($urandom_range(0, 1));
          bus.req_data[k*VEC_W +: VEC_W] = VEC_W'($urandom);
        end else if (!hold_req) begin
          bus.req_valid[k] = 1'b0;
        end
      end else if (rand_mode) begin
        if (!bus.req_valid[k] && $urandom_range(0, 3) == 0) begin
          bus.req_data[k*VEC_W +: VEC_W] = VEC_W'($urandom);
          bus.req_valid[k] = 1'b1;
        end else if (bus.req_valid[k] && $urandom_range(0, 15) == 0) begin
          bus.req_valid[k] = 1'b0;
        end
      end
    end
    if (hs_event || !bus.rnd_valid) bus.rnd_data = rand_word();
    if (stall_left > 0 && m_busy && !m_hs) begin
      bus.rnd_valid = 1'b0;
      stall_left--;
    end else begin
      bus.rnd_valid = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
    if (bp_left > 0 && m_busy && m_hs && (tcyc >= m_resp_cyc)) begin
      bus.rsp_ready = 1'b0;
      bp_left--;
    end else begin
      bus.rsp_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  endtask

  task automatic wait_evals(input int unsigned target, input int unsigned budget);
    int unsigned n = 0;
    while (evals < target && n < budget) begin
      drive_cycle();
      n++;
    end
    if (evals < target) chk("timeout_evals", evals, target);
  endtask

  task automatic wait_idle();
    int unsigned n = 0;
    while (m_busy && n < 200) begin
      drive_cycle();
      n++;
    end
    if (m_busy) chk("timeout_idle", 1, 0);
  endtask

  task automatic chk_log(input string name, input int unsigned idx, input int unsigned exp_id);
    if (glog_id.size() > idx) chk(name, glog_id[idx], exp_id);
    else chk({name, "_missing"}, glog_id.size(), idx + 1);
  endtask

  int unsigned gi, ri, a1, hs0, ev0;

  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.rnd_valid = 1'b0;
    bus.rnd_data  = rand_word();
    bus.rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Fairness: all requesters held high
    hold_req = 1'b1;
    for (int unsigned k = 0; k < N_REQ; k++) bus.req_data[k*VEC_W +: VEC_W] = VEC_W'($urandom);
    bus.req_valid = '1;
    gi = glog_id.size();
    wait_evals(evals + 8, 8 * 14 + 40);
    bus.req_valid = '0;
    wait_idle();
    for (int unsigned k = 0; k < 8; k++) begin
      chk_log("rr_order", gi + k, k % N_REQ);
      if (k > 0 && glog_cyc.size() > gi + k)
        chk("rr_spacing", glog_cyc[gi+k] - glog_cyc[gi+k-1], LATENCY + 3);
    end

    // Single request on requester 2
    hold_req = 1'b0;
    bus.req_data[2*VEC_W +: VEC_W] = {(VEC_W/8){8'hA5}};
    bus.req_valid = 4'b0100;
    gi = glog_id.size();
    ri = rise_cyc.size();
    wait_evals(evals + 1, 40);
    wait_idle();
    chk_log("single_grant", gi, 2);
    if (rise_cyc.size() > ri && glog_cyc.size() > gi)
      chk("single_latency", rise_cyc[ri] - glog_cyc[gi], LATENCY + 2);
    else chk("single_latency_missing", rise_cyc.size(), ri + 1);

    // PRNG stall of 5 cycles
    stall_left = 5;
    bus.req_valid = 4'b0001;
    gi = glog_id.size();
    ri = rise_cyc.size();
    wait_evals(evals + 1, 50);
    wait_idle();
    chk_log("stall_grant", gi, 0);
    if (rise_cyc.size() > ri && glog_cyc.size() > gi)
      chk("stall_latency", rise_cyc[ri] - glog_cyc[gi], LATENCY + 7);
    else chk("stall_latency_missing", rise_cyc.size(), ri + 1);

    // Backpressure of 7 cycles with another request pending
    hold_req = 1'b1;
    bp_left = 7;
    bus.req_valid = 4'b0011;
    gi = glog_id.size();
    ri = rise_cyc.size();
    wait_evals(evals + 1, 50);
    a1 = acc_cyc;
    wait_evals(evals + 1, 50);
    bus.req_valid = '0;
    wait_idle();
    hold_req = 1'b0;
    chk_log("bp_first_grant", gi, 1);
    chk_log("bp_second_grant", gi + 1, 0);
    if (rise_cyc.size() > ri) chk("bp_hold_cycles", a1 - rise_cyc[ri], 7);
    if (glog_cyc.size() > gi + 1) chk("bp_regrant", glog_cyc[gi+1] - a1, 1);

    // Reset during evaluation after serving requester 1
    bus.req_valid = 4'b0010;
    gi = glog_id.size();
    for (int unsigned n = 0; n < 20 && glog_id.size() == gi; n++) drive_cycle();
    chk_log("pre_reset_grant", gi, 1);
    repeat (5) drive_cycle();
    rst = 1'b0;
    #1;
    chk("reset_immediate", {bus.req_ready, bus.rnd_ready, bus.sbox_start, bus.rsp_valid,
                            bus.busy, bus.rsp_data, bus.rsp_id, bus.sbox_in}, '0);
    chk("reset_immediate_fresh", bus.sbox_fresh, '0);
    repeat (2) drive_cycle();
    rst = 1'b1;
    bus.req_valid = '1;
    gi = glog_id.size();
    wait_evals(evals + 1, 40);
    bus.req_valid = '0;
    wait_idle();
    chk_log("post_reset_grant", gi, 0);

    // Random traffic
    rand_mode = 1'b1;
    hs0 = handshakes;
    ev0 = evals;
    wait_evals(evals + 1000, 40000);
    rand_mode = 1'b0;
    bus.req_valid = '0;
    wait_idle();
    repeat (2) drive_cycle();
    chk("scoreboard_drain", exp_q.size(), 0);
    chk("prng_words_once", handshakes - hs0, evals - ev0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
